// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: command encoding and FSM states.
// The instruction decoder drives MDUOp from these same constants.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110,
    MDU_RSVD  = 3'b111
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// EX-stage connection of the MDU: command and operands in, busy status and HI/LO out.
interface mdu_if;

  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output MDUOp, A, B, input Busy, HI, LO);
  modport slave  (input MDUOp, A, B, output Busy, HI, LO);

endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: holds HI/LO, runs MULT*/DIV* for a fixed busy window and
// commits the result on the edge where Busy falls. MTHI/MTLO complete in one cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  mdu_op_e     op_in;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic [31:0] divisor;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq, ur;
  logic [31:0] sq_u, sr_u;
  logic [31:0] sq, sr;

  assign op_in = mdu_op_e'(bus.MDUOp);

  // Result datapath works only on the latched operands, so A/B may change during RUN.
  always_comb begin
    prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u   = {32'b0, a_q} * {32'b0, b_q};
    div_zero = (b_q == 32'b0);
    // Substitute a harmless divisor when dividing by zero; the result is discarded anyway.
    divisor  = div_zero ? 32'd1 : b_q;
    uq       = a_q / divisor;
    ur       = a_q % divisor;
    abs_a    = a_q[31] ? (32'b0 - a_q) : a_q;
    abs_b    = divisor[31] ? (32'b0 - divisor) : divisor;
    sq_u     = abs_a / abs_b;
    sr_u     = abs_a % abs_b;
    // Magnitude divide then re-sign: also yields 0x80000000 / 0 for the overflow case.
    sq       = (a_q[31] ^ divisor[31]) ? (32'b0 - sq_u) : sq_u;
    sr       = a_q[31] ? (32'b0 - sr_u) : sr_u;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        unique case (op_in)
          MDU_MULT, MDU_MULTU: begin
            op_d    = op_in;
            a_d     = bus.A;
            b_d     = bus.B;
            cnt_d   = CW'(MULT_CYCLES);
            state_d = ST_RUN;
          end
          MDU_DIV, MDU_DIVU: begin
            op_d    = op_in;
            a_d     = bus.A;
            b_d     = bus.B;
            cnt_d   = CW'(DIV_CYCLES);
            state_d = ST_RUN;
          end
          MDU_MTHI: hi_d = bus.A;
          MDU_MTLO: lo_d = bus.A;
          default: ;
        endcase
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          unique case (op_q)
            MDU_MULT:  {hi_d, lo_d} = prod_s;
            MDU_MULTU: {hi_d, lo_d} = prod_u;
            MDU_DIV: begin
              if (!div_zero) begin
                hi_d = sr;
                lo_d = sq;
              end
            end
            MDU_DIVU: begin
              if (!div_zero) begin
                hi_d = ur;
                lo_d = uq;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset aborts any operation in flight; HI/LO clear and the pending result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.Busy = (state_q == ST_RUN);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: busy window length, commit timing and
// hand-computed HI/LO results for each command, including the corner cases.
module tb_mdu;
  import mdu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a MULT*/DIV*, scramble A/B during RUN, count busy cycles (bounded).
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int exp_cyc);
    logic [31:0] hi_before;
    logic [31:0] lo_before;
    int n;
    hi_before = bus.HI;
    lo_before = bus.LO;
    bus.MDUOp = op;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.MDUOp = MDU_NONE;
    bus.A     = ~a;
    bus.B     = ~b ^ 32'h5A5A_0001;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      n++;
      if (n == 1) begin
        check({tag, "_hi_held"}, bus.HI, hi_before);
        check({tag, "_lo_held"}, bus.LO, lo_before);
      end
      tick();
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_cyc));
  endtask

  task automatic move_to(input logic [2:0] op, input logic [31:0] val);
    bus.MDUOp = op;
    bus.A     = val;
    tick();
    bus.MDUOp = MDU_NONE;
    bus.A     = 32'h0;
    check("mt_busy", 32'(bus.Busy), 32'h0);
  endtask

  initial begin
    int n;
    n_tests   = 0;
    n_fail    = 0;
    bus.MDUOp = MDU_NONE;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(bus.Busy), 32'h0);
    check("rst_hi", bus.HI, 32'h0);
    check("rst_lo", bus.LO, 32'h0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(bus.Busy), 32'h0);
    check("idle_hi", bus.HI, 32'h0);
    check("idle_lo", bus.LO, 32'h0);

    run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5);
    check("mult_hi", bus.HI, 32'hFFFF_FFFF);
    check("mult_lo", bus.LO, 32'hFFFF_FFFA);

    run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
    check("multu_hi", bus.HI, 32'h0000_0002);
    check("multu_lo", bus.LO, 32'hFFFF_FFFA);

    run_op("mult_min", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 5);
    check("mult_min_hi", bus.HI, 32'h4000_0000);
    check("mult_min_lo", bus.LO, 32'h0000_0000);

    run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_hi", bus.HI, 32'hFFFF_FFFF);
    check("div_lo", bus.LO, 32'hFFFF_FFFD);

    run_op("div_negb", MDU_DIV, 32'd7, 32'hFFFF_FFFE, 10);
    check("div_negb_hi", bus.HI, 32'h0000_0001);
    check("div_negb_lo", bus.LO, 32'hFFFF_FFFD);

    run_op("divu", MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 10);
    check("divu_hi", bus.HI, 32'h0000_000F);
    check("divu_lo", bus.LO, 32'h0FFF_FFFF);

    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    check("div_ovf_hi", bus.HI, 32'h0000_0000);
    check("div_ovf_lo", bus.LO, 32'h8000_0000);

    move_to(MDU_MTHI, 32'h1111_1111);
    check("mthi_hi", bus.HI, 32'h1111_1111);
    move_to(MDU_MTLO, 32'h1111_1111);
    check("mtlo_lo", bus.LO, 32'h1111_1111);
    check("mtlo_hi_kept", bus.HI, 32'h1111_1111);

    run_op("divu_zero", MDU_DIVU, 32'd7, 32'd0, 10);
    check("divu_zero_hi", bus.HI, 32'h1111_1111);
    check("divu_zero_lo", bus.LO, 32'h1111_1111);

    bus.MDUOp = 3'b111;
    bus.A     = 32'hCAFE_F00D;
    tick();
    bus.MDUOp = MDU_NONE;
    check("rsvd_busy", 32'(bus.Busy), 32'h0);
    check("rsvd_hi", bus.HI, 32'h1111_1111);
    check("rsvd_lo", bus.LO, 32'h1111_1111);

    // MTHI held during a MULT: ignored while busy, accepted in the first idle cycle.
    bus.MDUOp = MDU_MULT;
    bus.A     = 32'd3;
    bus.B     = 32'd5;
    tick();
    bus.MDUOp = MDU_MTHI;
    bus.A     = 32'hDEAD_BEEF;
    bus.B     = 32'h0;
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check("mthi_hold_busy_cycles", 32'(n), 32'd5);
    check("mthi_hold_prod_hi", bus.HI, 32'h0);
    check("mthi_hold_prod_lo", bus.LO, 32'd15);
    tick();
    bus.MDUOp = MDU_NONE;
    check("mthi_hold_hi", bus.HI, 32'hDEAD_BEEF);
    check("mthi_hold_lo", bus.LO, 32'd15);
    check("mthi_hold_idle", 32'(bus.Busy), 32'h0);

    // Reset in the third busy cycle of a DIV aborts it.
    bus.MDUOp = MDU_DIV;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    tick();
    bus.MDUOp = MDU_NONE;
    tick();
    tick();
    check("abort_busy_before", 32'(bus.Busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'h0);
    check("abort_hi", bus.HI, 32'h0);
    check("abort_lo", bus.LO, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("post_rst_mult", MDU_MULT, 32'd4, 32'd5, 5);
    check("post_rst_hi", bus.HI, 32'h0);
    check("post_rst_lo", bus.LO, 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
